// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       EXE_IsLoad,
    input  logic [4:0] EXE_Dst,
    input  logic       EXE_DivStart,
    input  logic       EXE_BranchTaken,
    input  logic       MEM_ExceptValid,
    input  logic       DMem_Busy,
    output logic       PC_Wr,
    output logic       IFID_Wr,
    output logic       IFID_Flush,
    output logic       IDEXE_Wr,
    output logic       IDEXE_Flush,
    output logic       EXEMEM_Wr,
    output logic       EXEMEM_Flush,
    output logic       MEMWB_Wr,
    output logic       MEMWB_Flush,
    output logic       Div_Busy,
    output logic       Div_Done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Cnt,
    output logic [31:0] Flush_Cnt
`endif
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DIV_WAIT  = 2'd1,
        EXC_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_div_cnt;
    logic             w_load_use;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_div_cnt == '0);
    assign w_load_use = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                        ((ID_UsesRs && (ID_Rs == EXE_Dst)) ||
                         (ID_UsesRt && (ID_Rt == EXE_Dst)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_div_cnt <= '0;
        end else if (MEM_ExceptValid) begin
            r_state   <= EXC_DRAIN;
            r_div_cnt <= '0;
        end else if (r_state == EXC_DRAIN) begin
            r_state <= RUN;
        end else if (DMem_Busy) begin
            // The divider keeps running while memory stalls; only the exit waits.
            if (r_state == DIV_WAIT && !w_cnt_zero)
                r_div_cnt <= r_div_cnt - 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (EXE_DivStart) begin
                        r_state   <= DIV_WAIT;
                        r_div_cnt <= CNT_START;
                    end
                end
                DIV_WAIT: begin
                    if (w_cnt_zero)
                        r_state <= RUN;
                    else
                        r_div_cnt <= r_div_cnt - 1'b1;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        PC_Wr        = 1'b1;
        IFID_Wr      = 1'b1;
        IFID_Flush   = 1'b0;
        IDEXE_Wr     = 1'b1;
        IDEXE_Flush  = 1'b0;
        EXEMEM_Wr    = 1'b1;
        EXEMEM_Flush = 1'b0;
        MEMWB_Wr     = 1'b1;
        MEMWB_Flush  = 1'b0;
        Div_Busy     = 1'b0;
        Div_Done     = 1'b0;
        if (rst) begin
            PC_Wr        = 1'b0;
            IFID_Wr      = 1'b0;
            IFID_Flush   = 1'b1;
            IDEXE_Wr     = 1'b0;
            IDEXE_Flush  = 1'b1;
            EXEMEM_Wr    = 1'b0;
            EXEMEM_Flush = 1'b1;
            MEMWB_Wr     = 1'b0;
            MEMWB_Flush  = 1'b1;
        end else if (MEM_ExceptValid) begin
            IFID_Flush   = 1'b1;
            IDEXE_Flush  = 1'b1;
            EXEMEM_Flush = 1'b1;
            MEMWB_Flush  = 1'b1;
        end else if (r_state == EXC_DRAIN) begin
            IFID_Flush = 1'b1;
        end else if (DMem_Busy) begin
            PC_Wr     = 1'b0;
            IFID_Wr   = 1'b0;
            IDEXE_Wr  = 1'b0;
            EXEMEM_Wr = 1'b0;
            MEMWB_Wr  = 1'b0;
            Div_Busy  = (r_state == DIV_WAIT);
        end else if (r_state == DIV_WAIT) begin
            Div_Busy = 1'b1;
            if (w_cnt_zero) begin
                Div_Done = 1'b1;
            end else begin
                PC_Wr        = 1'b0;
                IFID_Wr      = 1'b0;
                IDEXE_Wr     = 1'b0;
                EXEMEM_Flush = 1'b1;
            end
        end else if (EXE_DivStart) begin
            Div_Busy     = 1'b1;
            PC_Wr        = 1'b0;
            IFID_Wr      = 1'b0;
            IDEXE_Wr     = 1'b0;
            EXEMEM_Flush = 1'b1;
        end else if (w_load_use) begin
            PC_Wr       = 1'b0;
            IFID_Wr     = 1'b0;
            IDEXE_Flush = 1'b1;
        end else if (EXE_BranchTaken) begin
            // Delay-slot instruction in ID proceeds; only the fetch is squashed.
            IFID_Flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PC_Wr)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (IFID_Flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign Stall_Cnt = r_stall_cnt;
    assign Flush_Cnt = r_flush_cnt;
`endif

endmodule
